// File: rtl/cache_pkg.sv
// Shared I-cache definitions: fill-controller states, address field bounds,
// and helpers that derive block base and word addresses from a fetch address.
// Pure declarations; no logic of its own.
package cache_pkg;

  localparam int TAG_HI      = 15;
  localparam int ADDR_W      = TAG_HI + 1;
  localparam int SET_HI      = 9;
  localparam int OFFSET_HI   = 3;
  localparam int OFFSET_LO   = 1;
  localparam int BLOCK_WORDS = 8;

  // Byte-offset bits inside one block (16 bytes -> low 4 bits).
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << (OFFSET_HI + 1)) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    META   = 2'd2,
    SETTLE = 2'd3
  } fill_state_t;

  // Strip the in-block offset so the address points at word 0 of its block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

  // Address of 16-bit word 'idx' inside the block starting at 'base'.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0]        idx);
    return base | (ADDR_W'(idx) << OFFSET_LO);
  endfunction

endpackage

// File: rtl/word_counter_3.sv
// 3-bit word index counter with synchronous clear and increment enable.
// Latency: count updates on the clock edge after clr/inc; clear wins over inc.
// Backpressure: none; wraps 7 -> 0 naturally.
module word_counter_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt
);

  // Counter register: clear has priority, otherwise step when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (inc) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/icache_fill_fsm.sv
// I-cache miss fill controller: fetches an 8-word block and writes data then metadata.
// Latency: requests 1 cycle after Miss is sampled; metadata at 9+MEM_LAT; idle at 11+MEM_LAT.
// Backpressure: tolerates gaps in mem_data_valid; fsm_busy stalls fetch. Optional ICACHE_FILL_STATS_EN.
module icache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Miss,
  input  logic [ADDR_W-1:0] Addr_CPU,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] Addr_FSM,
  output logic [15:0]       DataIn_FSM,
  output logic              Data_WE,
  output logic              MetaData_WE
`ifdef ICACHE_FILL_STATS_EN
  ,
  output logic [15:0]       miss_count,
  output logic [15:0]       stall_cycles
`endif
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic              req_done_q;
  logic [2:0]        req_cnt;
  logic [2:0]        rcv_cnt;
  logic              start;
  logic              outstanding;
  logic              rcv_fire;

  assign start = (state_q == IDLE) && Miss;

  // A return is only accepted while some issued request is still unanswered;
  // once all 8 are issued, every remaining return belongs to this block.
  assign outstanding = req_done_q || (req_cnt != rcv_cnt);
  assign rcv_fire    = (state_q == FILL) && mem_data_valid && outstanding;

  assign DataIn_FSM = mem_data;
  assign mem_addr   = word_addr(base_q, req_cnt);

  word_counter_3 u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (mem_en),
    .cnt   (req_cnt)
  );

  word_counter_3 u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (rcv_fire),
    .cnt   (rcv_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: Miss only matters in IDLE; FILL ends on the 8th return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Miss) state_d = FILL;
      FILL:    if (rcv_fire && (rcv_cnt == 3'd7)) state_d = META;
      META:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request/write strobes per state; Addr_FSM holds when idle.
  always_comb begin
    fsm_busy    = 1'b0;
    mem_en      = 1'b0;
    Data_WE     = 1'b0;
    MetaData_WE = 1'b0;
    Addr_FSM    = addr_hold_q;
    case (state_q)
      FILL: begin
        fsm_busy = 1'b1;
        mem_en   = !req_done_q;
        if (rcv_fire) begin
          Data_WE  = 1'b1;
          Addr_FSM = word_addr(base_q, rcv_cnt);
        end
      end
      META: begin
        fsm_busy    = 1'b1;
        MetaData_WE = 1'b1;
        Addr_FSM    = base_q;
      end
      SETTLE: begin
        fsm_busy = 1'b1;
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

  // Fill context: block base, request-complete flag and last written address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      req_done_q  <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      if (start) begin
        base_q <= block_base(Addr_CPU);
      end
      if (start) begin
        req_done_q <= 1'b0;
      end else if (mem_en && (req_cnt == 3'd7)) begin
        req_done_q <= 1'b1;
      end
      if (Data_WE || MetaData_WE) begin
        addr_hold_q <= Addr_FSM;
      end
    end
  end

`ifdef ICACHE_FILL_STATS_EN
  // Saturating statistics: fills started and cycles spent stalling fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count   <= 16'h0000;
      stall_cycles <= 16'h0000;
    end else begin
      if (start && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
      if (fsm_busy && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'h0001;
      end
    end
  end
`endif

endmodule
